// File: rtl/transfer_sequencer.sv
// transfer_sequencer: bit/word timing counters, sign-time decode and the
// transfer FSM that holds TR across a commanded drum-word span, then emits a
// one-clock RC so the gate logic clears IS before the next command.
module transfer_sequencer #(
  parameter int unsigned WORDS = 108,
  parameter int unsigned BITS  = 29
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       BT,
  input  logic       HALT,
  input  logic       CMD_VALID,
  input  logic [6:0] CMD_T,
  input  logic       CMD_DEFER,
  input  logic       CMD_DP,
  output logic       CMD_READY,
  output logic       CMD_ERR,
  output logic       TS,
  output logic       TR,
  output logic       RC,
  output logic [4:0] BIT_T,
  output logic [6:0] WORD_T
);

  localparam logic [4:0] BitLast  = 5'(BITS - 1);
  localparam logic [6:0] WordLast = 7'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

  // Timing counters
  logic [4:0] bit_q;
  logic [6:0] word_q;

  // Transfer FSM state and latched command
  state_e     state_q;
  logic [6:0] t_q;
  logic       defer_q;
  logic       dp_q;
  logic [6:0] last_q;
  logic       tr_q;
  logic       rc_q;
  logic       err_q;

  // Decoded helpers
  logic       boundary;
  logic [6:0] word_nxt;
  logic [6:0] t_even;
  logic [6:0] last_imm;
  logic [6:0] last_dp;
  logic [6:0] last_sel;
  logic       start_hit;
  logic       cmd_in_range;

  assign boundary     = BT && (bit_q == BitLast);
  assign word_nxt     = (word_q == WordLast) ? 7'd0 : word_q + 7'd1;
  assign t_even       = {t_q[6:1], 1'b0};
  // Immediate spans end on the word before T; when the start word equals T
  // this makes last = start-1, i.e. the first match is one full revolution on.
  assign last_imm     = (t_q == 7'd0) ? WordLast : t_q - 7'd1;
  assign last_dp      = (t_even == WordLast) ? 7'd0 : t_even + 7'd1;
  assign cmd_in_range = 32'(CMD_T) < WORDS;

  // Start condition and last word for the latched command
  always_comb begin
    start_hit = 1'b0;
    last_sel  = t_q;
    if (!defer_q) begin
      start_hit = 1'b1;
      last_sel  = last_imm;
    end else if (dp_q) begin
      start_hit = (word_nxt == t_even);
      last_sel  = last_dp;
    end else begin
      start_hit = (word_nxt == t_q);
      last_sel  = t_q;
    end
  end

  // Bit and word counters advance only on bit-time strobes
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      bit_q  <= 5'd0;
      word_q <= 7'd0;
    end else if (BT) begin
      if (bit_q == BitLast) begin
        bit_q  <= 5'd0;
        word_q <= word_nxt;
      end else begin
        bit_q <= bit_q + 5'd1;
      end
    end
  end

  // Transfer FSM with registered TR / RC / CMD_ERR
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= 7'd0;
      defer_q <= 1'b0;
      dp_q    <= 1'b0;
      last_q  <= 7'd0;
      tr_q    <= 1'b0;
      rc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      rc_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (CMD_VALID && !HALT) begin
            if (cmd_in_range) begin
              t_q     <= CMD_T;
              defer_q <= CMD_DEFER;
              dp_q    <= CMD_DP;
              state_q <= StWait;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (boundary && !HALT && start_hit) begin
            tr_q    <= 1'b1;
            last_q  <= last_sel;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          // HALT deliberately ignored: a started transfer always completes
          if (boundary && (word_q == last_q)) begin
            tr_q    <= 1'b0;
            rc_q    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign CMD_READY = (state_q == StIdle) && !HALT;
  assign CMD_ERR   = err_q;
  assign TS        = (bit_q == 5'd0);
  assign TR        = tr_q;
  assign RC        = rc_q;
  assign BIT_T     = bit_q;
  assign WORD_T    = word_q;

  // TR and RC are pure functions of the FSM state by construction
  tr_matches_state : assert property (@(posedge CLOCK) tr_q == (state_q == StXfer));
  rc_matches_state : assert property (@(posedge CLOCK) rc_q == (state_q == StDone));

endmodule
